// File: rtl/hack_uart_tx_if.sv
// CPU-side write/status bundle for the Hack UART transmitter.
// The master is the CPU write-decode logic and the slave is the transmitter.
interface hack_uart_tx_if;
   logic       i_WR_EN;
   logic [7:0] i_WR_DATA;
   logic       i_CLR_OVF;
   logic       o_Serial_TX;
   logic       o_BUSY;
   logic       o_FULL;
   logic       o_EMPTY;
   logic       o_OVERFLOW;

   modport master (
      output i_WR_EN, i_WR_DATA, i_CLR_OVF,
      input  o_Serial_TX, o_BUSY, o_FULL, o_EMPTY, o_OVERFLOW
   );

   modport slave (
      input  i_WR_EN, i_WR_DATA, i_CLR_OVF,
      output o_Serial_TX, o_BUSY, o_FULL, o_EMPTY, o_OVERFLOW
   );
endinterface

// File: rtl/hack_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the Hack computer.
// A small FIFO feeds a start/data/stop frame FSM clocked by 16x-style oversampled baud counters.
module hack_uart_tx #(
   parameter int unsigned CLKS_PER_TICK = 325,
   parameter int unsigned TICKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic          i_CLK,
   input  logic          i_RESET,
   hack_uart_tx_if.slave bus
);

   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned TickW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam int unsigned SubW  = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

   localparam logic [TickW-1:0] TickMax = TickW'(CLKS_PER_TICK - 1);
   localparam logic [SubW-1:0]  SubMax  = SubW'(TICKS_PER_BIT - 1);
   localparam logic [CntW-1:0]  CntFull = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e            state_q, state_d;
   logic [TickW-1:0]  tick_q, tick_d;
   logic [SubW-1:0]   sub_q, sub_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              ovf_q, ovf_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [7:0]        mem_q [FIFO_DEPTH];

   logic full, empty, push, pop, bit_end;

   assign full    = (count_q == CntFull);
   assign empty   = (count_q == '0);
   assign bit_end = (tick_q == TickMax) && (sub_q == SubMax);

   // Frame FSM and baud counters.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      sub_d   = sub_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;

      if (state_q != StIdle) begin
         if (tick_q == TickMax) begin
            tick_d = '0;
            sub_d  = (sub_q == SubMax) ? '0 : sub_q + SubW'(1);
         end else begin
            tick_d = tick_q + TickW'(1);
         end
      end

      unique case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               tick_d  = '0;
               sub_d   = '0;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               tx_d    = shift_q[0];
               shift_d = {1'b1, shift_q[7:1]};
               bit_d   = 3'd0;
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b1, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               if (!empty) begin
                  // Next byte starts straight out of the stop bit, no idle gap.
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FIFO bookkeeping; full is the pre-edge value, so a write while full drops even with a pop.
   always_comb begin
      push     = bus.i_WR_EN && !full;
      wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
      ovf_d = ovf_q;
      if (bus.i_WR_EN && full) begin
         ovf_d = 1'b1;
      end else if (bus.i_CLR_OVF) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q  <= StIdle;
         tick_q   <= '0;
         sub_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         sub_q    <= sub_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.i_WR_DATA;
      end
   end

   assign bus.o_Serial_TX = tx_q;
   assign bus.o_BUSY      = (state_q != StIdle) || !empty;
   assign bus.o_FULL      = full;
   assign bus.o_EMPTY     = empty;
   assign bus.o_OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_hack_uart_tx.sv
// Bench for hack_uart_tx: frame-level reference model compared every cycle, directed scenarios
// with literal expectations, a simple UART receiver, and a randomized traffic phase.
module tb_hack_uart_tx;

   localparam int CPT   = 2;
   localparam int TPB   = 4;
   localparam int BITC  = CPT * TPB;
   localparam int FRAME = 10 * BITC;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;

   hack_uart_tx_if bus ();

   hack_uart_tx #(
      .CLKS_PER_TICK (CPT),
      .TICKS_PER_BIT (TPB),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .i_CLK   (clk),
      .i_RESET (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
         end
      end
   endtask

   // Reference model: bytes in a queue, each frame a 10-bit pattern timed from its start edge.
   logic [7:0] mq[$];
   logic [7:0] cur;
   int         cyc = 0;
   int         start = 0;
   bit         inflight = 0;
   bit         mdl_valid = 0;
   bit         m_ovf = 0;
   logic       exp_tx, exp_busy, exp_full, exp_empty;

   always @(posedge clk) begin
      int pre;
      int off;
      int idx;
      cyc++;
      if (rst) begin
         mq.delete();
         inflight  = 0;
         m_ovf     = 0;
         mdl_valid = 1;
      end else if (mdl_valid) begin
         pre = mq.size();
         if (inflight && (cyc - start) == FRAME) inflight = 0;
         if (!inflight && pre > 0) begin
            cur      = mq.pop_front();
            start    = cyc;
            inflight = 1;
         end
         if (bus.i_WR_EN && pre < DEPTH) mq.push_back(bus.i_WR_DATA);
         if (bus.i_WR_EN && pre == DEPTH) m_ovf = 1;
         else if (bus.i_CLR_OVF) m_ovf = 0;
      end
      exp_tx = 1'b1;
      if (inflight) begin
         off = cyc - start;
         idx = off / BITC;
         if (idx == 0) exp_tx = 1'b0;
         else if (idx <= 8) exp_tx = cur[idx-1];
      end
      exp_busy  = inflight || (mq.size() > 0);
      exp_full  = (mq.size() == DEPTH);
      exp_empty = (mq.size() == 0);
   end

   always @(negedge clk) begin
      if (mdl_valid) begin
         check("tx",       bus.o_Serial_TX, exp_tx);
         check("busy",     bus.o_BUSY,      exp_busy);
         check("full",     bus.o_FULL,      exp_full);
         check("empty",    bus.o_EMPTY,     exp_empty);
         check("overflow", bus.o_OVERFLOW,  m_ovf);
      end
   end

   // Simple receiver sampling mid-bit; decoded bytes go to rxq.
   logic [7:0] rxq[$];
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (bus.o_Serial_TX === 1'b0 && !rst) begin
            repeat (BITC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BITC) @(negedge clk);
               b[i] = bus.o_Serial_TX;
            end
            repeat (BITC) @(negedge clk);
            rxq.push_back(b);
         end
      end
   end

   task automatic wr_byte(input logic [7:0] d);
      bus.i_WR_EN   = 1'b1;
      bus.i_WR_DATA = d;
      @(negedge clk);
      bus.i_WR_EN   = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int act;
      rst           = 1'b1;
      bus.i_WR_EN   = 1'b1;
      bus.i_WR_DATA = 8'hAA;
      bus.i_CLR_OVF = 1'b0;

      // 1: reset held with write strobe active.
      wait_cyc(3);
      check("rst_tx",    bus.o_Serial_TX, 1'b1);
      check("rst_busy",  bus.o_BUSY,      1'b0);
      check("rst_empty", bus.o_EMPTY,     1'b1);
      check("rst_full",  bus.o_FULL,      1'b0);
      check("rst_ovf",   bus.o_OVERFLOW,  1'b0);
      rst         = 1'b0;
      bus.i_WR_EN = 1'b0;
      wait_cyc(20);
      check("rst_idle_tx", bus.o_Serial_TX, 1'b1);
      check("rst_no_rx",   rxq.size(),      0);

      // 2: single 0x41 frame, literal line timing.
      rxq.delete();
      wr_byte(8'h41);
      for (int n = 1; n <= 81; n++) begin
         @(negedge clk);
         case (n)
            1:  check("f41_start_first", bus.o_Serial_TX, 1'b0);
            8:  check("f41_start_last",  bus.o_Serial_TX, 1'b0);
            9:  check("f41_b0",          bus.o_Serial_TX, 1'b1);
            17: check("f41_b1",          bus.o_Serial_TX, 1'b0);
            57: check("f41_b6",          bus.o_Serial_TX, 1'b1);
            65: check("f41_b7",          bus.o_Serial_TX, 1'b0);
            72: check("f41_b7_last",     bus.o_Serial_TX, 1'b0);
            73: check("f41_stop",        bus.o_Serial_TX, 1'b1);
            80: check("f41_busy_hold",   bus.o_BUSY,      1'b1);
            81: check("f41_busy_fall",   bus.o_BUSY,      1'b0);
            default: ;
         endcase
      end
      wait_cyc(10);
      check("f41_rx_n", rxq.size(), 1);
      if (rxq.size() > 0) check("f41_rx", rxq[0], 8'h41);

      // 3: three back-to-back frames.
      rxq.delete();
      wr_byte(8'h41);
      wr_byte(8'h42);
      wr_byte(8'h0D);
      for (int n = 3; n <= 241; n++) begin
         @(negedge clk);
         case (n)
            80:  check("b2b_stop1",   bus.o_Serial_TX, 1'b1);
            81:  check("b2b_start2",  bus.o_Serial_TX, 1'b0);
            160: check("b2b_stop2",   bus.o_Serial_TX, 1'b1);
            161: check("b2b_start3",  bus.o_Serial_TX, 1'b0);
            240: check("b2b_busy",    bus.o_BUSY,      1'b1);
            241: check("b2b_idle",    bus.o_BUSY,      1'b0);
            default: ;
         endcase
      end
      wait_cyc(10);
      check("b2b_rx_n", rxq.size(), 3);
      if (rxq.size() == 3) begin
         check("b2b_rx0", rxq[0], 8'h41);
         check("b2b_rx1", rxq[1], 8'h42);
         check("b2b_rx2", rxq[2], 8'h0D);
      end

      // 4: overflow with six writes.
      rxq.delete();
      for (int i = 0; i < 6; i++) begin
         wr_byte(8'h10 + 8'(i));
         if (i == 4) begin
            check("ovf_full5", bus.o_FULL,     1'b1);
            check("ovf_clr5",  bus.o_OVERFLOW, 1'b0);
         end
         if (i == 5) begin
            check("ovf_set6",  bus.o_OVERFLOW, 1'b1);
            check("ovf_full6", bus.o_FULL,     1'b1);
         end
      end
      wait_cyc(5 * FRAME + 20);
      check("ovf_rx_n", rxq.size(), 5);
      if (rxq.size() == 5) begin
         for (int i = 0; i < 5; i++) check("ovf_rx", rxq[i], 8'h10 + 8'(i));
      end
      bus.i_CLR_OVF = 1'b1;
      @(negedge clk);
      bus.i_CLR_OVF = 1'b0;
      check("ovf_cleared", bus.o_OVERFLOW, 1'b0);

      // 5: reset during data bit 3 of 0x55 with two bytes queued.
      rxq.delete();
      wr_byte(8'h55);
      wr_byte(8'hA0);
      wr_byte(8'hA1);
      wait_cyc(34);
      check("abort_pre_busy", bus.o_BUSY, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_tx",    bus.o_Serial_TX, 1'b1);
      check("abort_empty", bus.o_EMPTY,     1'b1);
      act = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.o_Serial_TX !== 1'b1) act++;
      end
      check("abort_quiet", act, 0);
      rxq.delete();

      // 6: write and clear on the same edge while full.
      for (int i = 0; i < 5; i++) wr_byte(8'h60 + 8'(i));
      check("setwin_full", bus.o_FULL, 1'b1);
      bus.i_WR_EN   = 1'b1;
      bus.i_WR_DATA = 8'h99;
      bus.i_CLR_OVF = 1'b1;
      @(negedge clk);
      bus.i_WR_EN   = 1'b0;
      bus.i_CLR_OVF = 1'b0;
      check("setwin_ovf",   bus.o_OVERFLOW, 1'b1);
      check("setwin_full2", bus.o_FULL,     1'b1);
      wait_cyc(5 * FRAME + 20);
      check("setwin_rx_n", rxq.size(), 5);
      if (rxq.size() == 5) check("setwin_last", rxq[4], 8'h64);

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 3000; i++) begin
         bus.i_WR_EN   = ($urandom_range(0, 99) < 12);
         bus.i_WR_DATA = 8'($urandom);
         bus.i_CLR_OVF = ($urandom_range(0, 99) < 4);
         rst           = ($urandom_range(0, 999) < 3);
         @(negedge clk);
      end
      bus.i_WR_EN   = 1'b0;
      bus.i_CLR_OVF = 1'b0;
      rst           = 1'b0;
      wait_cyc((DEPTH + 2) * FRAME);
      check("rand_drained", bus.o_BUSY, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
